// File: rtl/dm_pkg.sv
// Shared encodings for the display source arbiter: mode codes, FSM states and source limits.
package dm_pkg;

  localparam int MAX_SRC = 4;

  localparam logic [1:0] MODE_AUTO   = 2'b00;
  localparam logic [1:0] MODE_MANUAL = 2'b01;
  localparam logic [1:0] MODE_FREEZE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEEK = 2'd1,
    ST_LOAD = 2'd2,
    ST_SHOW = 2'd3
  } state_t;

  // The unused code 11 behaves exactly like FREEZE everywhere, including prog.
  function automatic logic [1:0] mode_eff_f(input logic [1:0] m);
    return (m == 2'b11) ? MODE_FREEZE : m;
  endfunction

endpackage

// File: rtl/dspl_src_arbiter_dwell_timer.sv
// Dwell counter: counts while en, clears on clr, pulses tc on the cycle the count sits at DWELL-1.
module dwell_timer #(
  parameter int DWELL = 100_000_000,
  parameter int CNT_W = 27
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt;

  assign tc = en && !clr && (cnt == CNT_W'(DWELL - 1));

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dspl_src_arbiter.sv
// Picks one requesting source for the 8-digit display (auto round-robin, manual step or frozen)
// and drives its word, index and status onto registered display outputs.
module dspl_src_arbiter
  import dm_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int DWELL = 100_000_000,
  parameter int CNT_W = 27
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_SRC-1:0]     req,
  input  logic [16*N_SRC-1:0]  src_data,
  input  logic [1:0]           mode,
  input  logic                 btn_next,
  output logic [N_SRC-1:0]     ack,
  output logic [15:0]          data_2,
  output logic [1:0]           module_d,
  output logic [2:0]           prog
);

  state_t                  state;
  logic [1:0]              sel;
  logic [1:0]              cand;
  logic [2:0]              misses;
  logic                    no_src;
  logic [1:0]              mode_r;
  logic [1:0]              prog_mode;

  logic [1:0]              mode_eff;
  logic                    mode_chg;
  logic [MAX_SRC-1:0]      req_pad;
  logic [16*MAX_SRC-1:0]   data_pad;
  logic [1:0]              widx;
  logic [15:0]             word;
  logic [MAX_SRC-1:0]      oh;
  logic                    tmr_clr;
  logic                    tmr_en;
  logic                    tc;
  logic                    advance;

  function automatic logic [1:0] nxt(input logic [1:0] i);
    return (i == 2'(N_SRC - 1)) ? 2'd0 : i + 2'd1;
  endfunction

  assign mode_eff = mode_eff_f(mode);
  assign mode_chg = (mode != mode_r);
  assign req_pad  = MAX_SRC'(req);
  assign data_pad = (16*MAX_SRC)'(src_data);
  assign widx     = (state == ST_LOAD) ? cand : sel;
  assign word     = data_pad[{widx, 4'b0000} +: 16];
  assign oh       = MAX_SRC'(1) << cand;

  // The counter only runs while showing in AUTO; any mode edit restarts the dwell.
  assign tmr_en  = (state == ST_SHOW) && (mode_eff == MODE_AUTO);
  assign tmr_clr = mode_chg || (state != ST_SHOW) || (mode_eff == MODE_MANUAL);

  assign advance = ((mode_eff == MODE_AUTO) && tc) ||
                   ((mode_eff == MODE_MANUAL) && btn_next);

  assign prog = {no_src, prog_mode};

  dwell_timer #(
    .DWELL (DWELL),
    .CNT_W (CNT_W)
  ) u_dwell (
    .clock (clock),
    .reset (reset),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .tc    (tc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      sel       <= 2'd0;
      cand      <= 2'd0;
      misses    <= 3'd0;
      data_2    <= 16'd0;
      module_d  <= 2'd0;
      ack       <= '0;
      no_src    <= 1'b1;
      mode_r    <= mode;
      prog_mode <= mode_eff;
    end else begin
      ack       <= '0;
      mode_r    <= mode;
      prog_mode <= mode_eff;
      case (state)
        ST_IDLE: begin
          data_2 <= 16'd0;
          no_src <= 1'b1;
          if (|req) begin
            state  <= ST_SEEK;
            cand   <= sel;
            misses <= 3'd0;
          end
        end
        ST_SEEK: begin
          if (req_pad[cand]) begin
            state <= ST_LOAD;
          end else begin
            cand <= nxt(cand);
            if (misses == 3'(N_SRC - 1)) begin
              state  <= ST_IDLE;
              data_2 <= 16'd0;
              no_src <= 1'b1;
            end else begin
              misses <= misses + 3'd1;
            end
          end
        end
        ST_LOAD: begin
          sel      <= cand;
          module_d <= cand;
          data_2   <= word;
          ack      <= oh[N_SRC-1:0];
          no_src   <= 1'b0;
          state    <= ST_SHOW;
        end
        ST_SHOW: begin
          // A vanished source wins over any advance and freezes the last shown word.
          if (!req_pad[sel]) begin
            state  <= ST_SEEK;
            cand   <= nxt(sel);
            misses <= 3'd0;
          end else begin
            data_2 <= word;
            if (advance) begin
              state  <= ST_SEEK;
              cand   <= nxt(sel);
              misses <= 3'd0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dspl_src_arbiter.sv
// Directed bench for dspl_src_arbiter with N_SRC=4, DWELL=4; outputs sampled on the falling edge.
module tb_dspl_src_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [63:0] src_data;
  logic [1:0]  mode;
  logic        btn_next;
  logic [3:0]  ack;
  logic [15:0] data_2;
  logic [1:0]  module_d;
  logic [2:0]  prog;

  logic [15:0] w [4];
  int checks   = 0;
  int failures = 0;
  int n;
  int seen;

  assign src_data = {w[3], w[2], w[1], w[0]};

  always #5 clock = ~clock;

  dspl_src_arbiter #(
    .N_SRC (4),
    .DWELL (4),
    .CNT_W (3)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .src_data (src_data),
    .mode     (mode),
    .btn_next (btn_next),
    .ack      (ack),
    .data_2   (data_2),
    .module_d (module_d),
    .prog     (prog)
  );

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ticks until an ack appears; returns the number of rising edges it took (40 = gave up).
  task automatic wait_ack(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (ack == 4'b0000 && cnt < 40);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) w[i] = 16'hA0A0 + 16'(i);
    reset = 1'b1; req = 4'hF; mode = 2'b00; btn_next = 1'b0;

    // 1. reset held three cycles with every source requesting
    tick(); tick(); tick();
    chk("rst_data",   32'(data_2),   32'h0);
    chk("rst_md",     32'(module_d), 32'h0);
    chk("rst_ack",    32'(ack),      32'h0);
    chk("rst_prog",   32'(prog),     32'h4);
    reset = 1'b0;
    tick();
    chk("rel1_ack",   32'(ack),      32'h0);
    tick();
    chk("rel2_ack",   32'(ack),      32'h0);
    chk("rel2_prog",  32'(prog),     32'h4);
    tick();
    chk("rel3_ack",   32'(ack),      32'h1);
    chk("rel3_md",    32'(module_d), 32'h0);
    chk("rel3_data",  32'(data_2),   32'hA0A0);
    chk("rel3_prog",  32'(prog),     32'h0);

    // 2. AUTO round-robin over 0,1,3 with source 2 absent
    req = 4'b1011;
    wait_ack(n);
    chk("auto1_gap",  32'(n),        32'd6);
    chk("auto1_ack",  32'(ack),      32'h2);
    chk("auto1_md",   32'(module_d), 32'h1);
    chk("auto1_data", 32'(data_2),   32'hA0A1);
    wait_ack(n);
    chk("auto3_gap",  32'(n),        32'd7);
    chk("auto3_ack",  32'(ack),      32'h8);
    chk("auto3_md",   32'(module_d), 32'h3);
    chk("auto3_data", 32'(data_2),   32'hA0A3);
    wait_ack(n);
    chk("auto0_gap",  32'(n),        32'd6);
    chk("auto0_ack",  32'(ack),      32'h1);
    chk("auto0_md",   32'(module_d), 32'h0);
    chk("auto0_data", 32'(data_2),   32'hA0A0);

    // 3. MANUAL stepping; button held through SEEK/LOAD must not queue
    mode = 2'b01; req = 4'hF;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ack != 4'b0000) seen++;
    end
    chk("man_idle_acks", 32'(seen),     32'd0);
    chk("man_idle_md",   32'(module_d), 32'h0);
    chk("man_prog",      32'(prog),     32'h1);
    btn_next = 1'b1;
    tick(); tick(); tick();
    btn_next = 1'b0;
    chk("man1_ack",  32'(ack),      32'h2);
    chk("man1_md",   32'(module_d), 32'h1);
    chk("man1_data", 32'(data_2),   32'hA0A1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ack != 4'b0000) seen++;
    end
    chk("man_hold_acks", 32'(seen),     32'd0);
    chk("man_hold_md",   32'(module_d), 32'h1);
    btn_next = 1'b1;
    tick();
    btn_next = 1'b0;
    wait_ack(n);
    chk("man2_gap",  32'(n),        32'd2);
    chk("man2_ack",  32'(ack),      32'h4);
    chk("man2_md",   32'(module_d), 32'h2);

    // 4. move to source 1 by dropping others, then drop req[1] together with a button
    req = 4'b0010;
    wait_ack(n);
    chk("to1_gap",   32'(n),        32'd5);
    chk("to1_ack",   32'(ack),      32'h2);
    chk("to1_md",    32'(module_d), 32'h1);
    req = 4'b1101; btn_next = 1'b1; w[1] = 16'hBEEF;
    tick();
    btn_next = 1'b0;
    chk("drop_hold", 32'(data_2),   32'hA0A1);
    chk("drop_ack",  32'(ack),      32'h0);
    wait_ack(n);
    chk("drop_gap",  32'(n),        32'd2);
    chk("drop_ack2", 32'(ack),      32'h4);
    chk("drop_md",   32'(module_d), 32'h2);
    chk("drop_data", 32'(data_2),   32'hA0A2);
    w[1] = 16'hA0A1;

    // 5. every request falls: IDLE after exactly N_SRC+1 edges
    req = 4'b0000;
    tick(); tick(); tick(); tick();
    chk("exh4_prog", 32'(prog),     32'h1);
    tick();
    chk("exh5_prog", 32'(prog),     32'h5);
    chk("exh5_data", 32'(data_2),   32'h0);
    req = 4'b0100;
    wait_ack(n);
    chk("re2_gap",   32'(n),        32'd3);
    chk("re2_ack",   32'(ack),      32'h4);
    chk("re2_md",    32'(module_d), 32'h2);
    chk("re2_data",  32'(data_2),   32'hA0A2);

    // 6. short AUTO spell, then FREEZE with a live-changing word, then AUTO from a fresh dwell
    mode = 2'b00;
    tick(); tick();
    mode = 2'b10; req = 4'hF;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      w[2] = 16'h5000 + 16'(k);
      btn_next = (k == 2);
      tick();
      chk("frz_data", 32'(data_2), 32'h5000 + 32'(k));
      if (ack != 4'b0000 || module_d != 2'd2) seen++;
    end
    btn_next = 1'b0;
    chk("frz_stable", 32'(seen), 32'd0);
    chk("frz_prog",   32'(prog), 32'h2);
    mode = 2'b00;
    wait_ack(n);
    chk("unfrz_gap",  32'(n),        32'd7);
    chk("unfrz_ack",  32'(ack),      32'h8);
    chk("unfrz_md",   32'(module_d), 32'h3);
    chk("unfrz_data", 32'(data_2),   32'hA0A3);

    // reset taken in the middle of SEEK
    req = 4'b0000;
    tick();
    reset = 1'b1;
    tick();
    chk("mrst_md",   32'(module_d), 32'h0);
    chk("mrst_data", 32'(data_2),   32'h0);
    chk("mrst_prog", 32'(prog),     32'h4);
    reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
